// File: rtl/gray_win_pkg.sv
// gray_win_pkg: shared widths and packed-window indexing for the 3x3 window generator.
`default_nettype none

package gray_win_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_W = 72;

  // Bit offset of pixel (i,j) in the packed window; p00 sits at the top, p22 at the bottom.
  function automatic int pix(input int i, input int j);
    return (8 - i * 3 - j) * PIX_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_line_buffer.sv
// gray_line_buffer: single-port line memory, asynchronous read-before-write at the write address.
`default_nettype none

module gray_line_buffer #(
  parameter int DEPTH  = 28,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // No reset so the array maps onto distributed RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

`default_nettype wire

// File: rtl/gray_window3x3.sv
// gray_window3x3: streams 8-bit gray pixels in raster order and emits every fully
// interior 3x3 neighbourhood, registered, one cycle after its newest pixel.
`default_nettype none

module gray_window3x3
  import gray_win_pkg::*;
#(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic             I_clk,
  input  logic             I_reset_n,
  input  logic             I_frame_sync,
  input  logic             I_pixel_data_valid,
  input  logic [PIX_W-1:0] I_pixel_data_Gray,
  output logic             O_window_valid,
  output logic [WIN_W-1:0] O_window,
  output logic             O_frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]    col_cnt, col_eff;
  logic [RW-1:0]    row_cnt, row_eff;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [WIN_W-1:0] win_q, win_base, win_d;
  logic             emit, done_d;

  // A sync pulse makes the current pixel (if any) position (0,0) of a new frame.
  assign col_eff = I_frame_sync ? '0 : col_cnt;
  assign row_eff = I_frame_sync ? '0 : row_cnt;

  gray_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .DATA_W(PIX_W),
    .ADDR_W(CW)
  ) u_lb0 (
    .clk  (I_clk),
    .we   (I_pixel_data_valid),
    .addr (col_eff),
    .wdata(I_pixel_data_Gray),
    .rdata(lb0_rd)
  );

  gray_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .DATA_W(PIX_W),
    .ADDR_W(CW)
  ) u_lb1 (
    .clk  (I_clk),
    .we   (I_pixel_data_valid),
    .addr (col_eff),
    .wdata(lb0_rd),
    .rdata(lb1_rd)
  );

  always_comb begin
    win_base = I_frame_sync ? '0 : win_q;
    win_d    = win_base;
    if (I_pixel_data_valid) begin
      for (int i = 0; i < 3; i++) begin
        win_d[pix(i, 0) +: PIX_W] = win_base[pix(i, 1) +: PIX_W];
        win_d[pix(i, 1) +: PIX_W] = win_base[pix(i, 2) +: PIX_W];
      end
      win_d[pix(0, 2) +: PIX_W] = lb1_rd;
      win_d[pix(1, 2) +: PIX_W] = lb0_rd;
      win_d[pix(2, 2) +: PIX_W] = I_pixel_data_Gray;
    end
  end

  assign emit   = I_pixel_data_valid && (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);
  assign done_d = emit && (row_eff == ROW_LAST) && (col_eff == COL_LAST);

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      col_cnt        <= '0;
      row_cnt        <= '0;
      win_q          <= '0;
      O_window_valid <= 1'b0;
      O_window       <= '0;
      O_frame_done   <= 1'b0;
    end else begin
      win_q          <= win_d;
      O_window_valid <= emit;
      O_frame_done   <= done_d;
      if (emit) O_window <= win_d;
      if (I_pixel_data_valid) begin
        if (col_eff == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
        end else begin
          col_cnt <= col_eff + 1'b1;
          row_cnt <= row_eff;
        end
      end else if (I_frame_sync) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire
